// File: rtl/reg_read_port.sv
// reg_read_port
// Operand-fetch stage on the read side of the 16 x 16-bit register bank.
// It accepts a decoded instruction (register indices plus an optional
// immediate) over a valid/ready request handshake. It selects both operands
// from the bank, with same-cycle bypass from the ALU result bus. It then
// presents the registered operands to the ALU over a valid/ready output
// handshake. The stage holds a single entry and has one cycle of latency.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   r0..r15    current register bank contents
//   ALUBus     value being written into the bank this cycle
//   regEnable  per-register write enables for this cycle (bit i writes r_i)
//   req_valid  request present
//   req_ready  stage can accept a request this cycle
//   rdst       destination / first-operand register index
//   rsrc       source register index
//   use_imm    take operand B from the extended immediate instead of r[rsrc]
//   imm        immediate field
//   op_valid   operands valid
//   op_ready   ALU consumes the operands this cycle
//   opA        operand A (contents of rdst)
//   opB        operand B (contents of rsrc or the extended immediate)
//   op_dst     rdst carried alongside the operands for writeback
module reg_read_port #(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 8,
  parameter int IMM_SIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r4,
  input  logic [DATA_W-1:0] r5,
  input  logic [DATA_W-1:0] r6,
  input  logic [DATA_W-1:0] r7,
  input  logic [DATA_W-1:0] r8,
  input  logic [DATA_W-1:0] r9,
  input  logic [DATA_W-1:0] r10,
  input  logic [DATA_W-1:0] r11,
  input  logic [DATA_W-1:0] r12,
  input  logic [DATA_W-1:0] r13,
  input  logic [DATA_W-1:0] r14,
  input  logic [DATA_W-1:0] r15,
  input  logic [DATA_W-1:0] ALUBus,
  input  logic [15:0]       regEnable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        rdst,
  input  logic [3:0]        rsrc,
  input  logic              use_imm,
  input  logic [IMM_W-1:0]  imm,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [3:0]        op_dst
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [3:0]        op_dst_q, op_dst_d;

  logic [DATA_W-1:0] bank   [16];
  logic [DATA_W-1:0] bypass [16];
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              imm_fill;
  logic              accept;
  logic              consume;

  // Handshake terms. req_ready is a pure pass-through of op_ready when full,
  // which is what gives one operand per cycle while the ALU keeps accepting.
  assign op_valid  = (state_q == FULL);
  assign req_ready = !op_valid || op_ready;
  assign accept    = req_valid && req_ready;
  assign consume   = op_valid && op_ready;

  // Per-register bypass: a register being written this cycle yields the
  // value on the ALU bus, not its stale contents. Each enable bit is
  // evaluated on its own, so a multi-hot regEnable still bypasses every
  // matching index.
  always_comb begin
    bank[0]  = r0;   bank[1]  = r1;   bank[2]  = r2;   bank[3]  = r3;
    bank[4]  = r4;   bank[5]  = r5;   bank[6]  = r6;   bank[7]  = r7;
    bank[8]  = r8;   bank[9]  = r9;   bank[10] = r10;  bank[11] = r11;
    bank[12] = r12;  bank[13] = r13;  bank[14] = r14;  bank[15] = r15;
    for (int i = 0; i < 16; i++) begin
      bypass[i] = regEnable[i] ? ALUBus : bank[i];
    end
  end

  // Immediate extension. The fill bit is the immediate's MSB when signed and
  // zero otherwise.
  always_comb begin
    imm_fill = (IMM_SIGNED != 0) ? imm[IMM_W-1] : 1'b0;
    imm_ext  = {{(DATA_W-IMM_W){imm_fill}}, imm};
  end

  // Operand selection. rdst == rsrc is allowed, and both operands then see
  // the same bypassed value.
  always_comb begin
    sel_a = bypass[rdst];
    sel_b = use_imm ? imm_ext : bypass[rsrc];
  end

  // Next-state logic: fill on accept, stay full while a new request replaces
  // the consumed one or while stalled, and drain on a consume with no accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (consume && !accept) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Operand payload: captured only on accept. While stalled, or after a
  // drain, the held operands stay bit-stable. Later bank writes do not
  // refresh a held entry; upstream logic is responsible for that hazard.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_dst_d = op_dst_q;
    if (accept) begin
      opa_d    = sel_a;
      opb_d    = sel_b;
      op_dst_d = rdst;
    end
  end

  // State register. Reset clears both the valid state and the payload
  // immediately, which discards any operand that is still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      opa_q    <= '0;
      opb_q    <= '0;
      op_dst_q <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_dst_q <= op_dst_d;
    end
  end

  assign opA    = opa_q;
  assign opB    = opb_q;
  assign op_dst = op_dst_q;

endmodule
